// File: rtl/auth_pkg.sv
// Shared types and helpers for the rider-authentication controller.
package auth_pkg;

  typedef enum logic [2:0] {OFF, AUTH, PWR, STOP_PEND, OFF_WAIT, LOCK} state_t;

  localparam logic [7:0] GO_BYTE   = 8'h67;
  localparam logic [7:0] STOP_BYTE = 8'h73;

  // Key bytes are sent most-significant first: idx 0 is KEY[8*key_len-1 -: 8].
  function automatic logic [7:0] key_byte(input logic [31:0] key, input int key_len,
                                          input int idx);
    logic [31:0] sh;
    sh = key >> (8 * (key_len - 1 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/auth_ctrl_if.sv
// Byte handshake between the UART receiver and the authentication controller.
interface auth_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rdy;

  modport master (output rx_data, rx_rdy, input clr_rdy);
  modport slave  (input rx_data, rx_rdy, output clr_rdy);
endinterface

// File: rtl/auth_timer.sv
// Loadable saturating up-counter; tc_o flags that the count sits at MAX.
module auth_timer #(
  parameter int MAX = 1,
  parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (clr_i)                      cnt_q <= '0;
    else if (ld_i)                       cnt_q <= ld_val_i;
    else if (en_i && cnt_q != W'(MAX))   cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/auth_ctrl.sv
// Rider authentication / power sequencing. Define AUTH_LOCKOUT_EN to add the
// repeated-failure lockout (LOCK state, fail counter, locked output).
module auth_ctrl
  import auth_pkg::*;
#(
  parameter int          KEY_LEN   = 1,
  parameter logic [31:0] KEY       = {24'h0, GO_BYTE},
  parameter logic [7:0]  STOP_CODE = STOP_BYTE,
  parameter int          AUTH_TMO  = 50000,
  parameter int          OFF_DLY   = 1000,
  parameter int          MAX_FAIL  = 3,
  parameter int          LOCK_CYC  = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  auth_ctrl_if.slave  rx,
  input  logic        rider_off,
  output logic        pwr_up,
  output logic        auth_fail,
  output logic        locked
);

  localparam logic [7:0] KEY0 = key_byte(KEY, KEY_LEN, 0);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       fail_evt, tmo_tc, dly_tc;
  logic       key0_hit, stop_hit;

  assign key0_hit = rx.rx_rdy && (rx.rx_data == KEY0);
  assign stop_hit = rx.rx_rdy && (rx.rx_data == STOP_CODE);

  // Inter-byte gap: any byte restarts the count.
  auth_timer #(.MAX(AUTH_TMO - 1)) u_tmo (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q != AUTH || rx.rx_rdy),
    .ld_i(1'b0), .ld_val_i('0), .en_i(1'b1), .tc_o(tmo_tc));

  auth_timer #(.MAX(OFF_DLY - 1)) u_dly (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q != OFF_WAIT),
    .ld_i(1'b0), .ld_val_i('0), .en_i(1'b1), .tc_o(dly_tc));

`ifdef AUTH_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_q, fail_d;
  logic          lock_tc, lock_now;

  auth_timer #(.MAX(LOCK_CYC - 1)) u_lock (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q != LOCK),
    .ld_i(1'b0), .ld_val_i('0), .en_i(1'b1), .tc_o(lock_tc));

  assign lock_now = (fail_q == FW'(MAX_FAIL - 1));

  always_comb begin
    fail_d = fail_q;
    if (state_q == LOCK || (state_d == PWR && state_q != PWR)) fail_d = '0;
    else if (fail_evt && fail_q != FW'(MAX_FAIL))               fail_d = fail_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fail_q <= '0;
    else        fail_q <= fail_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_evt = 1'b0;
    case (state_q)
      OFF: if (key0_hit) begin
        if (KEY_LEN == 1) state_d = PWR;
        else begin
          state_d = AUTH;
          idx_d   = 2'd1;
        end
      end
      AUTH: begin
        if (rx.rx_rdy) begin
          if (rx.rx_data == key_byte(KEY, KEY_LEN, int'(idx_q))) begin
            if (int'(idx_q) == KEY_LEN - 1) state_d = PWR;
            else                            idx_d   = idx_q + 2'd1;
          end else fail_evt = 1'b1;
        end else if (tmo_tc) fail_evt = 1'b1;
        if (fail_evt) begin
`ifdef AUTH_LOCKOUT_EN
          state_d = lock_now ? LOCK : OFF;
`else
          state_d = OFF;
`endif
        end
      end
      PWR: if (stop_hit) state_d = rider_off ? OFF_WAIT : STOP_PEND;
      STOP_PEND: begin
        if (key0_hit)       state_d = PWR;
        else if (rider_off) state_d = OFF_WAIT;
      end
      // A key byte cancels the stop even if the rider steps back on that cycle.
      OFF_WAIT: begin
        if (key0_hit)        state_d = PWR;
        else if (!rider_off) state_d = STOP_PEND;
        else if (dly_tc)     state_d = OFF;
      end
`ifdef AUTH_LOCKOUT_EN
      LOCK: if (lock_tc) state_d = OFF;
`endif
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    rx.clr_rdy = rx.rx_rdy;
    pwr_up     = (state_q == PWR) || (state_q == STOP_PEND) || (state_q == OFF_WAIT);
    auth_fail  = fail_evt;
`ifdef AUTH_LOCKOUT_EN
    locked     = (state_q == LOCK);
`else
    locked     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_auth_ctrl.sv
// Bench for auth_ctrl: directed vector table, multi-cycle sequences and random
// traffic, all checked against a protocol-level reference model.
module tb_auth_ctrl;

  localparam int          KL = 2;
  localparam logic [31:0] KY = 32'h4767;
  localparam int          OD = 4;
  localparam int          AT = 16;
  localparam int          MF = 2;
  localparam int          LC = 20;
`ifdef AUTH_LOCKOUT_EN
  localparam bit LOCKEN = 1'b1;
`else
  localparam bit LOCKEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rider_off = 1'b0;
  logic pwr_up, auth_fail, locked;

  auth_ctrl_if bus();

  auth_ctrl #(.KEY_LEN(KL), .KEY(KY), .STOP_CODE(8'h73), .AUTH_TMO(AT), .OFF_DLY(OD),
              .MAX_FAIL(MF), .LOCK_CYC(LC)) dut (
    .clk(clk), .rst_n(rst_n), .rx(bus.slave), .rider_off(rider_off),
    .pwr_up(pwr_up), .auth_fail(auth_fail), .locked(locked));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key progress, power flag, stop request, rider-off run.
  logic [7:0] keyb [KL] = '{8'h47, 8'h67};
  int m_kpos, m_idle, m_fails, m_lock, m_wait;
  bit m_on, m_stop;

  task automatic model_reset();
    m_kpos = 0; m_idle = 0; m_fails = 0; m_lock = 0; m_wait = -1;
    m_on = 1'b0; m_stop = 1'b0;
  endtask

  function automatic bit model_fail(input bit rdy, input logic [7:0] d);
    if (m_on || m_lock > 0 || m_kpos == 0) return 1'b0;
    return rdy ? (d != keyb[m_kpos]) : (m_idle == AT - 1);
  endfunction

  task automatic model_power_on();
    m_on = 1'b1; m_kpos = 0; m_fails = 0; m_stop = 1'b0; m_wait = -1;
  endtask

  task automatic model_upd(input bit rdy, input logic [7:0] d, input bit ro);
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (!m_on) begin
      if (m_kpos == 0) begin
        if (rdy && d == keyb[0]) begin
          m_kpos = 1; m_idle = 0;
          if (KL == 1) model_power_on();
        end
      end else if (model_fail(rdy, d)) begin
        m_kpos = 0; m_idle = 0; m_fails++;
        if (LOCKEN && m_fails >= MF) m_lock = LC;
      end else if (rdy) begin
        m_kpos++; m_idle = 0;
        if (m_kpos == KL) model_power_on();
      end else m_idle++;
    end else if (!m_stop) begin
      if (rdy && d == 8'h73) begin
        m_stop = 1'b1;
        m_wait = ro ? 0 : -1;
      end
    end else if (rdy && d == keyb[0]) begin
      m_stop = 1'b0; m_wait = -1;
    end else if (m_wait < 0) begin
      if (ro) m_wait = 0;
    end else if (!ro) m_wait = -1;
    else if (m_wait == OD - 1) begin
      m_on = 1'b0; m_stop = 1'b0; m_wait = -1;
    end else m_wait++;
  endtask

  // One clock: drive on the falling edge, compare mid-low-phase, advance model.
  task automatic step(input bit rdy, input logic [7:0] d, input bit ro,
                      output logic a_pwr, output logic a_fail);
    @(negedge clk);
    bus.rx_rdy  = rdy;
    bus.rx_data = d;
    rider_off   = ro;
    #1;
    chk("clr_rdy", bus.clr_rdy, rdy);
    chk("pwr_up", pwr_up, m_on);
    chk("auth_fail", auth_fail, model_fail(rdy, d));
    chk("locked", locked, m_lock > 0);
    a_pwr  = pwr_up;
    a_fail = auth_fail;
    @(posedge clk);
    model_upd(rdy, d, ro);
  endtask

  typedef struct {
    bit         rdy;
    logic [7:0] d;
    bit         ro;
    bit         pwr;
    bit         fail;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rdy, input logic [7:0] d, input bit ro, input bit pwr,
                     input bit fail);
    vec_t v;
    v.rdy = rdy; v.d = d; v.ro = ro; v.pwr = pwr; v.fail = fail;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.rx_rdy = 1'b0; rider_off = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  logic ap, af;
  int   lk_cnt;
  bit   held;

  initial begin
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00;
    model_reset();

    // Power-up, stop with rider bounce, then timeout and mismatch failures.
    add(1, 8'h47, 0, 0, 0); add(1, 8'h67, 0, 0, 0); add(0, 8'h00, 0, 1, 0);
    add(1, 8'h73, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 1, 1, 0);
    add(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0);
    add(1, 8'h47, 0, 0, 0);
    for (int i = 1; i < AT; i++) add(0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1); add(0, 8'h00, 0, 0, 0);
    add(1, 8'h47, 0, 0, 0); add(1, 8'h12, 0, 0, 1); add(0, 8'h00, 0, 0, 0);

    @(posedge clk); #1;
    chk("rst_pwr_up", pwr_up, 1'b0);
    chk("rst_auth_fail", auth_fail, 1'b0);
    chk("rst_locked", locked, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].d, tbl[i].ro, ap, af);
      chk("tbl_pwr", ap, tbl[i].pwr);
      chk("tbl_fail", af, tbl[i].fail);
    end

    // Stop cancelled by key0 on the second OFF_WAIT cycle.
    do_reset();
    step(1, 8'h47, 0, ap, af); step(1, 8'h67, 0, ap, af); step(0, 8'h00, 1, ap, af);
    step(1, 8'h73, 1, ap, af); step(0, 8'h00, 1, ap, af);
    held = 1'b1;
    step(1, 8'h47, 1, ap, af); held &= ap;
    for (int i = 0; i < 6; i++) begin step(0, 8'h00, 1, ap, af); held &= ap; end
    chk("cancel_held", held, 1'b1);

    // Key0 wins over rider_off falling in the same OFF_WAIT cycle.
    step(1, 8'h73, 1, ap, af);
    step(1, 8'h47, 0, ap, af);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, ap, af);
    chk("prio_stays_pwr", ap, 1'b1);
    step(1, 8'h73, 1, ap, af);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, ap, af);
    chk("prio_then_off", ap, 1'b0);

`ifdef AUTH_LOCKOUT_EN
    do_reset();
    step(1, 8'h47, 0, ap, af); step(1, 8'h12, 0, ap, af);
    step(1, 8'h47, 0, ap, af); step(1, 8'h55, 0, ap, af);
    lk_cnt = 0;
    for (int i = 0; i < LC + 5; i++) begin
      if (i == 3)      step(1, 8'h47, 0, ap, af);
      else if (i == 4) step(1, 8'h67, 0, ap, af);
      else             step(0, 8'h00, 0, ap, af);
      if (locked) lk_cnt++;
    end
    chk("lock_len_20", lk_cnt == LC, 1'b1);
    step(1, 8'h47, 0, ap, af); step(1, 8'h67, 0, ap, af); step(0, 8'h00, 0, ap, af);
    chk("unlock_pwr", ap, 1'b1);
`endif

    // Asynchronous reset while powered.
    do_reset();
    step(1, 8'h47, 0, ap, af); step(1, 8'h67, 0, ap, af); step(0, 8'h00, 0, ap, af);
    @(negedge clk); #3;
    rst_n = 1'b0; #1;
    chk("async_rst_pwr", pwr_up, 1'b0);
    @(negedge clk); rst_n = 1'b1; model_reset();
    step(1, 8'h67, 0, ap, af); step(0, 8'h00, 0, ap, af);
    chk("post_rst_off", ap, 1'b0);
    step(1, 8'h47, 0, ap, af); step(1, 8'h67, 0, ap, af); step(0, 8'h00, 0, ap, af);
    chk("post_rst_key", ap, 1'b1);

    // Random traffic biased toward protocol bytes.
    do_reset();
    begin
      bit ro_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
        bit         rdy_r;
        logic [7:0] d_r;
        rdy_r = ($urandom_range(0, 9) < 4);
        case ($urandom_range(0, 3))
          0:       d_r = 8'h47;
          1:       d_r = 8'h67;
          2:       d_r = 8'h73;
          default: d_r = 8'($urandom_range(0, 255));
        endcase
        if ($urandom_range(0, 5) == 0) ro_r = ~ro_r;
        step(rdy_r, d_r, ro_r, ap, af);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
